mdu_unit: RTL and testbench
===========================

Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined MIPS core; executes mult, multu, div, divu, mthi and mtlo.
- Sits beside the E-stage ALU. Decode-stage hazard logic stalls any MDU instruction (including mfhi/mflo) while start or busy is high.
- Latency is configurable so the core can model realistic multi-cycle arithmetic.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; op/a/b are valid in the same cycle.
- op  in  4  operation code (mdu_pkg encoding).
- a  in  WIDTH  rs operand.
- b  in  WIDTH  rt operand.
- busy  out  1  registered; high while an operation is in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: busy=0, hi=0, lo=0, counter=0, state IDLE. Reset mid-operation aborts the operation and HI/LO return to 0.
- States:
  - IDLE: start with mult/multu moves to RUN with cnt=MULT_CYCLES; start with div/divu moves to RUN with cnt=DIV_CYCLES. Operands and op are latched at the start edge.
  - RUN: cnt decrements every cycle. When cnt==1, HI/LO are written and the unit returns to IDLE.
- Timing: for start in cycle t, busy=1 in cycles t+1..t+N and new hi/lo are visible from cycle t+N+1. busy falls in the same cycle HI/LO update.
- mthi/mtlo: single cycle, no busy. hi (or lo) <= a at the next edge; the other register is unchanged.
- start while busy: ignored (protocol violation, prevented by hazard logic); in-flight state is unchanged.
- Arithmetic:
  - mult: signed 2*WIDTH product, {hi,lo}=a*b.
  - multu: unsigned 2*WIDTH product, {hi,lo}=a*b.
  - div: signed; quotient truncates toward zero, remainder takes the dividend's sign; lo=quotient, hi=remainder.
  - divu: unsigned; lo=quotient, hi=remainder.
- Boundaries:
  - Division by zero (b==0): full DIV_CYCLES latency, HI/LO unchanged.
  - Signed MIN/-1: lo=MIN, hi=0.
- Unknown op with start: no effect, busy stays 0.

Optional Feature:
- Macro MDU_MADD_EN.
- Defined: adds ops madd, maddu, msub, msubu. Latency MULT_CYCLES. {hi,lo} <= {hi,lo} ± product, with 2*WIDTH wrap-around. The accumulator base is HI/LO as of completion, not as of start.
- Undefined: these opcodes decode as unknown (no effect).

Decomposition:
- mdu_pkg holds:
  - Op encodings: MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6, MDU_MADD=7, MDU_MADDU=8, MDU_MSUB=9, MDU_MSUBU=10.
  - The state enum {IDLE, RUN}.
- One sub-module, mdu_divider: combinational signed/unsigned divide with the zero-divisor and overflow cases resolved. It is instantiated once.
- The counter/FSM and HI/LO registers stay in mdu_unit.

Test Plan:
- mult, a=0xFFFFFFFE, b=3, MULT_CYCLES=5 -> busy high 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- divu, a=100, b=7, DIV_CYCLES=10 -> busy 10 cycles; lo=14, hi=2.
- div, a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then div with b=0 -> busy 10 cycles, HI/LO unchanged.
- div, a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- mthi a=0x1234 followed by mtlo a=0x5678 in the next cycle -> hi=0x1234, lo=0x5678, busy never asserted. Then start mult, assert reset on its 3rd busy cycle -> busy=0, hi=lo=0 next cycle.
- MDU_MADD_EN defined: hi=0, lo=0xFFFFFFFF, madd a=1, b=1 -> hi=1, lo=0. Then start a mult while busy (illegal) -> ignored, original result intact.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encodings, FSM state
// type and operand-signedness decode.
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MTHI  = 4'd5;
  localparam logic [3:0] MDU_MTLO  = 4'd6;
  localparam logic [3:0] MDU_MADD  = 4'd7;
  localparam logic [3:0] MDU_MADDU = 4'd8;
  localparam logic [3:0] MDU_MSUB  = 4'd9;
  localparam logic [3:0] MDU_MSUBU = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  // Ops whose operands are two's-complement
  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD) || (op == MDU_MSUB);
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Combinational signed/unsigned divider. Signed division works on magnitudes so
// the quotient truncates toward zero and the remainder follows the dividend.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_zero
);

  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_q_mag;
  logic [WIDTH-1:0] w_r_mag;

  assign w_a_neg    = i_signed & i_dividend[WIDTH-1];
  assign w_b_neg    = i_signed & i_divisor[WIDTH-1];
  assign w_a_mag    = w_a_neg ? (-i_dividend) : i_dividend;
  assign w_b_mag    = w_b_neg ? (-i_divisor) : i_divisor;
  assign o_div_zero = (i_divisor == '0);

  // MIN / -1: |MIN| = 2^(W-1) unsigned, negated back to MIN with remainder 0
  assign w_q_mag = o_div_zero ? '0 : (w_a_mag / w_b_mag);
  assign w_r_mag = o_div_zero ? '0 : (w_a_mag % w_b_mag);

  assign o_quotient  = (w_a_neg ^ w_b_neg) ? (-w_q_mag) : w_q_mag;
  assign o_remainder = w_a_neg ? (-w_r_mag) : w_r_mag;

endmodule

// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers.
// Optional build macro MDU_MADD_EN adds madd/maddu/msub/msubu.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] MULT_CNT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_CNT  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mdu_state_e       r_state;
  mdu_state_e       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic [3:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;

  logic w_is_mul;
  logic w_is_div;
  logic w_accept;
  logic w_launch;
  logic w_done;

  always_comb begin
    w_is_mul = (op == MDU_MULT) || (op == MDU_MULTU);
`ifdef MDU_MADD_EN
    w_is_mul = w_is_mul || (op == MDU_MADD) || (op == MDU_MADDU) ||
               (op == MDU_MSUB) || (op == MDU_MSUBU);
`endif
    w_is_div = (op == MDU_DIV) || (op == MDU_DIVU);
  end

  // Requests arriving while busy are dropped; hazard logic should prevent them
  assign w_accept = start && (r_state == IDLE);
  assign w_launch = w_accept && (w_is_mul || w_is_div);
  assign w_done   = (r_state == RUN) && (r_cnt == CNT_ONE);

  logic                   w_signed;
  logic [2*WIDTH-1:0]     w_mul_a;
  logic [2*WIDTH-1:0]     w_mul_b;
  logic [2*WIDTH-1:0]     w_prod;
  logic [WIDTH-1:0]       w_quot;
  logic [WIDTH-1:0]       w_rem;
  logic                   w_div_zero;

  // Extending to 2W before multiplying gives the exact signed or unsigned product
  assign w_signed = op_is_signed(r_op);
  assign w_mul_a  = w_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_mul_b  = w_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod   = w_mul_a * w_mul_b;

`ifdef MDU_MADD_EN
  logic [2*WIDTH-1:0] w_acc;
  assign w_acc = {r_hi, r_lo};
`endif

  mdu_divider #(
    .WIDTH(WIDTH)
  ) u_divider (
    .i_dividend (r_a),
    .i_divisor  (r_b),
    .i_signed   (r_op == MDU_DIV),
    .o_quotient (w_quot),
    .o_remainder(w_rem),
    .o_div_zero (w_div_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_hi    <= w_hi_next;
      r_lo    <= w_lo_next;
      if (w_launch) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_launch) begin
          w_state_next = RUN;
          w_cnt_next   = w_is_mul ? MULT_CNT : DIV_CNT;
        end
      end
      RUN: begin
        w_cnt_next = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // HI/LO update: moves at accept, arithmetic results on the final busy cycle
  always_comb begin
    w_hi_next = r_hi;
    w_lo_next = r_lo;
    if (w_accept && (op == MDU_MTHI)) begin
      w_hi_next = a;
    end
    if (w_accept && (op == MDU_MTLO)) begin
      w_lo_next = a;
    end
    if (w_done) begin
      case (r_op)
        MDU_MULT, MDU_MULTU: {w_hi_next, w_lo_next} = w_prod;
        MDU_DIV, MDU_DIVU: begin
          if (!w_div_zero) begin
            w_hi_next = w_rem;
            w_lo_next = w_quot;
          end
        end
`ifdef MDU_MADD_EN
        MDU_MADD, MDU_MADDU: {w_hi_next, w_lo_next} = w_acc + w_prod;
        MDU_MSUB, MDU_MSUBU: {w_hi_next, w_lo_next} = w_acc - w_prod;
`endif
        default: ;
      endcase
    end
  end

  assign busy = (r_state == RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_mdu_unit.sv
// Self-checking bench for mdu_unit: directed literal cases plus a random
// stream compared every cycle against a transaction-level arithmetic model.
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  mdu_unit #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk  (clk),
    .reset(reset),
    .start(start),
    .op   (op),
    .a    (a),
    .b    (b),
    .busy (busy),
    .hi   (hi),
    .lo   (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference arithmetic; bit 64 says whether HI/LO are written
  function automatic logic [64:0] ref_result(input logic [3:0] o, input logic [31:0] x,
                                             input logic [31:0] y, input logic [63:0] acc);
    longint          ps;
    longint unsigned pu;
    int              sx;
    int              sy;
    logic [63:0]     r;
    ps = longint'($signed(x)) * longint'($signed(y));
    pu = {32'd0, x} * {32'd0, y};
    sx = $signed(x);
    sy = $signed(y);
    r  = acc;
    case (o)
      MDU_MULT:  return {1'b1, 64'(ps)};
      MDU_MULTU: return {1'b1, 64'(pu)};
      MDU_DIV: begin
        if (sy == 0) return {1'b0, acc};
        if (sx == 32'sh80000000 && sy == -1) return {1'b1, 32'd0, 32'h80000000};
        r = {32'(sx % sy), 32'(sx / sy)};
        return {1'b1, r};
      end
      MDU_DIVU: begin
        if (y == 0) return {1'b0, acc};
        return {1'b1, x % y, x / y};
      end
`ifdef MDU_MADD_EN
      MDU_MADD:  return {1'b1, acc + 64'(ps)};
      MDU_MADDU: return {1'b1, acc + 64'(pu)};
      MDU_MSUB:  return {1'b1, acc - 64'(ps)};
      MDU_MSUBU: return {1'b1, acc - 64'(pu)};
`endif
      default: return {1'b0, acc};
    endcase
  endfunction

  // Model: an accepted op completes at a known edge number
  int          edges = 0;
  bit          m_pend = 0;
  int          m_done = 0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0;
  logic [31:0] m_b = '0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [64:0] m_res;

  always @(posedge clk) begin
    edges++;
    if (reset) begin
      m_pend = 0;
      m_hi   = '0;
      m_lo   = '0;
    end else if (m_pend) begin
      if (edges == m_done) begin
        m_res = ref_result(m_op, m_a, m_b, {m_hi, m_lo});
        if (m_res[64]) {m_hi, m_lo} = m_res[63:0];
        m_pend = 0;
      end
    end else if (start) begin
      case (op)
        MDU_MULT, MDU_MULTU
`ifdef MDU_MADD_EN
        , MDU_MADD, MDU_MADDU, MDU_MSUB, MDU_MSUBU
`endif
        : begin
          m_pend = 1; m_done = edges + MC; m_op = op; m_a = a; m_b = b;
        end
        MDU_DIV, MDU_DIVU: begin
          m_pend = 1; m_done = edges + DC; m_op = op; m_a = a; m_b = b;
        end
        MDU_MTHI: m_hi = a;
        MDU_MTLO: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (edges > 0) begin
      chk("busy_vs_model", {31'd0, busy}, {31'd0, m_pend});
      chk("hi_vs_model", hi, m_hi);
      chk("lo_vs_model", lo, m_lo);
    end
  end

  // Issue one op and count busy cycles; optionally fire an illegal start while busy
  task automatic do_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input bit intrude, output int nbusy);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0;
    while (busy && nbusy < 100) begin
      nbusy++;
      if (intrude && nbusy == 1) begin
        start = 1'b1; op = MDU_MULT; a = 32'd7; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    if (nbusy >= 100) chk("busy_timeout", 32'(nbusy), 32'd0);
    $display("op=%0d a=0x%08h b=0x%08h busy_cycles=%0d hi=0x%08h lo=0x%08h",
             o, x, y, nbusy, hi, lo);
  endtask

  int n;

  initial begin
    reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_hi", hi, 32'd0);
    chk("reset_lo", lo, 32'd0);
    reset = 1'b0;

    do_op(MDU_MULT, 32'hFFFFFFFE, 32'd3, 0, n);
    chk("mult_cycles", 32'(n), 32'd5);
    chk("mult_hi", hi, 32'hFFFFFFFF);
    chk("mult_lo", lo, 32'hFFFFFFFA);

    do_op(MDU_DIVU, 32'd100, 32'd7, 0, n);
    chk("divu_cycles", 32'(n), 32'd10);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);

    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, 0, n);
    chk("div_lo", lo, 32'hFFFFFFFD);
    chk("div_hi", hi, 32'hFFFFFFFF);

    do_op(MDU_DIV, 32'd55, 32'd0, 0, n);
    chk("div0_cycles", 32'(n), 32'd10);
    chk("div0_lo", lo, 32'hFFFFFFFD);
    chk("div0_hi", hi, 32'hFFFFFFFF);

    do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 0, n);
    chk("ovf_lo", lo, 32'h80000000);
    chk("ovf_hi", hi, 32'd0);

    do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, n);
    chk("multu_hi", hi, 32'hFFFFFFFE);
    chk("multu_lo", lo, 32'h00000001);

    // Back-to-back mthi/mtlo, then reset on the 3rd busy cycle of a mult
    @(negedge clk);
    start = 1'b1; op = MDU_MTHI; a = 32'h1234;
    @(negedge clk);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    op = MDU_MTLO; a = 32'h5678;
    @(negedge clk);
    chk("mtlo_busy", {31'd0, busy}, 32'd0);
    start = 1'b0;
    chk("mt_hi", hi, 32'h1234);
    chk("mt_lo", lo, 32'h5678);
    $display("mthi/mtlo hi=0x%08h lo=0x%08h", hi, lo);
    start = 1'b1; op = MDU_MULT; a = 32'd3; b = 32'd4;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    $display("reset mid-op busy=%0b hi=0x%08h lo=0x%08h", busy, hi, lo);

    // Illegal start while busy must not disturb the in-flight divide
    do_op(MDU_DIVU, 32'd100, 32'd7, 1, n);
    chk("intrude_cycles", 32'(n), 32'd10);
    chk("intrude_lo", lo, 32'd14);
    chk("intrude_hi", hi, 32'd2);

`ifdef MDU_MADD_EN
    do_op(MDU_MTHI, 32'd0, 32'd0, 0, n);
    do_op(MDU_MTLO, 32'hFFFFFFFF, 32'd0, 0, n);
    do_op(MDU_MADD, 32'd1, 32'd1, 1, n);
    chk("madd_cycles", 32'(n), 32'd5);
    chk("madd_hi", hi, 32'd1);
    chk("madd_lo", lo, 32'd0);
    do_op(MDU_MSUBU, 32'd2, 32'd1, 0, n);
    chk("msubu_hi", hi, 32'd0);
    chk("msubu_lo", lo, 32'hFFFFFFFE);
`else
    do_op(MDU_MADD, 32'd1, 32'd1, 0, n);
    chk("madd_off_cycles", 32'(n), 32'd0);
    chk("madd_off_hi", hi, 32'd2);
    chk("madd_off_lo", lo, 32'd14);
`endif

    do_op(4'd15, 32'hDEAD, 32'hBEEF, 0, n);
    chk("unknown_cycles", 32'(n), 32'd0);

    // Random stream: random starts every cycle, corner operands, rare resets
    for (int i = 0; i < 4000; i++) begin
      int sel;
      @(negedge clk);
      sel   = int'($urandom_range(0, 7));
      start = ($urandom_range(0, 2) == 0);
      op    = 4'($urandom_range(0, 15));
      a     = $urandom;
      b     = $urandom;
      if (sel == 0) b = 32'd0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) begin a = $urandom_range(0, 20); b = $urandom_range(0, 5); end
      if (sel == 3) b = -$urandom_range(1, 9);
      reset = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
    repeat (DC + 2) @(negedge clk);
    chk("final_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
